fp32_mant_sum_pipe: RTL and testbench
=====================================

// Module: fp32_mant_sum_pipe
// PURPOSE
//  Downstream stage of the 8-input FP32 aligner. Consumes 8 aligned 27-bit mantissas, signs, specials flags and the shared max exponent.
//  Produces one signed-magnitude sum, the exponent and special flags; the normalize/round stage consumes them.
//  Two's-complement conversion, 3-level adder tree, valid/ready-pipelined.
// PARAMETERS
//  NUM_INPUTS   8    operand count; fixed at 8, tree depth 3 (elaboration error otherwise)
//  MANT_W       27   aligned mantissa width (`ALIGNED_MANT_WIDTH)
//  SUM_W        30   result magnitude width = MANT_W + log2(NUM_INPUTS)
// PORTS
//  clk                  in   1        single clock, rising edge
//  rst                  in   1        synchronous, active-high reset
//  in_valid             in   1        input bundle valid
//  in_ready             out  1        stage accepts bundle this cycle
//  in_signs             in   8        per-operand sign
//  in_max_exponent      in   8        shared biased exponent from aligner
//  in_mantissas_flat    in   8*27     aligned magnitudes; operand i at [i*27 +: 27]
//  in_is_infs           in   8        per-operand infinity flag
//  in_is_nans           in   8        per-operand NaN flag
//  out_valid            out  1        result valid
//  out_ready            in   1        consumer accepts result
//  out_sign             out  1        result sign
//  out_exponent         out  8        = in_max_exponent of the bundle
//  out_mag              out  30       |sum|, binary point same as input (bit 26 = 1.0)
//  out_is_zero/inf/nan  out  1 each   result class (mutually exclusive)
// BEHAVIOUR
//  - Both edges use clk only; rst is synchronous and active-high.
//  - Reset: out_valid=0, all result regs 0, stage-valid bits 0. After reset, in_ready=1.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv; all stage regs load only when adv.
//  - Transfer on in_valid&in_ready. Output holds stable while out_valid&!out_ready.
//  - A bubble propagates as valid=0. Data regs may hold stale values when valid=0.
//  - S1, cycle 1: each op -> 28-bit signed (sign ? -mant : mant). Level-1 pair sums are 29-bit and registered with exponent, specials and signs.
//  - S2, cycle 2: level-2 sums are 30-bit, level-3 sum is 31-bit signed. Then convert: out_sign = sum[30], out_mag = abs(sum)[29:0].
//  - Latency 2 cycles from accept to out_valid. Throughput 1 bundle/cycle with no stall.
//  - Specials, highest priority first:
//    * NaN if any in_is_nans, or +inf and -inf both present.
//    * Otherwise inf if any inf; out_sign = the sign of that inf.
//    * Otherwise zero if sum==0; out_sign = &in_signs, so -0 only if all signs set.
//    * For NaN/inf: out_mag=0, out_exponent=8'hFF, out_sign=0 for NaN.
//  - Sum never overflows: 8*(2^27-1) < 2^30.
//  - rst during stall or with data in flight: every in-flight bundle is dropped and out_valid=0 next cycle.
//  - in_valid with in_ready=0 is ignored. The upstream must hold the bundle.
// CONFIGURATION
//  FP32_SUM_MID_REG_EN defined: extra register between tree level 2 and level 3.
//   Latency becomes 3 cycles; same stall/adv rule; reset and specials unchanged.
//  FP32_SUM_MID_REG_EN undefined: latency 2 as above.
// STRUCTURE
//  - fp32_defines.vh gains `SUM_WIDTH (30) and `SUM_SIGNED_WIDTH (31), next to `ALIGNED_MANT_WIDTH and `EXP_WIDTH.
//  - One sub-module fp32_signed_pair_add #(W): sign-extends two W-bit signed inputs and adds them to a W+1-bit output.
//    It is combinational, instantiated 7 times in the tree.
//  - Specials resolved in S1 into a 2-bit class register; it travels with the data.
// TESTING
//  1. 8 ops 27'h4000000 (1.0), signs 0, exp 127 -> after 2 clk: mag 30'h20000000, sign 0, exp 127, all flags 0.
//  2. 4x +27'h4000000 and 4x -27'h4000000 -> is_zero=1, sign 0. Same with all signs=1 and mant=0 -> is_zero=1, sign 1.
//  3. op0 +27'h0000003, op1 -27'h4000000, rest 0 -> sign 1, mag 30'h3FFFFFD.
//  4. is_infs=8'h01 (sign0) plus is_infs bit1 with sign1 -> is_nan=1, exp 8'hFF. Single +inf -> is_inf=1, sign 0.
//  5. Stream 5 bundles, out_ready=0 for cycles 3-6:
//     in_ready low while stalled; outputs held; no loss/duplication; order kept.
//  6. Assert rst for 1 clk with 2 bundles in flight -> out_valid=0 next clk; next bundle emerges after normal latency.
//     Repeat 1-6 with FP32_SUM_MID_REG_EN (latency 3).

Source files
------------

// File: rtl/fp32_mant_sum_pipe_pkg.sv
// Shared widths, result class encoding and stage metadata for the
// FP32 8-input mantissa sum pipeline.
package fp32_mant_sum_pipe_pkg;

  localparam int NUM_INPUTS = 8;
  localparam int MANT_W     = 27;
  localparam int EXP_W      = 8;
  localparam int LVLS       = $clog2(NUM_INPUTS);
  localparam int OP_W       = MANT_W + 1;
  localparam int SUM_W      = MANT_W + LVLS;
  localparam int SUM_SW     = SUM_W + 1;

  typedef enum logic [1:0] {
    CLS_NUM = 2'd0,
    CLS_INF = 2'd1,
    CLS_NAN = 2'd2
  } cls_e;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    cls_e             cls;
    logic             inf_neg;
    logic             all_neg;
  } meta_t;

  function automatic logic [OP_W-1:0] to_op(
    input logic              s,
    input logic [MANT_W-1:0] m
  );
    logic [OP_W-1:0] v;
    v = {1'b0, m};
    return s ? -v : v;
  endfunction

endpackage

// File: rtl/fp32_mant_sum_pipe_if.sv
// Valid/ready bundle between aligner, sum stage and normalizer.
// slave: sum stage side; master: producer/consumer side.
interface fp32_mant_sum_pipe_if;
  import fp32_mant_sum_pipe_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_INPUTS-1:0]        in_signs;
  logic [EXP_W-1:0]             in_max_exponent;
  logic [NUM_INPUTS*MANT_W-1:0] in_mantissas_flat;
  logic [NUM_INPUTS-1:0]        in_is_infs;
  logic [NUM_INPUTS-1:0]        in_is_nans;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_sign;
  logic [EXP_W-1:0]             out_exponent;
  logic [SUM_W-1:0]             out_mag;
  logic                         out_is_zero;
  logic                         out_is_inf;
  logic                         out_is_nan;

  modport slave (
    input  in_valid, in_signs, in_max_exponent,
    input  in_mantissas_flat, in_is_infs, in_is_nans,
    output in_ready,
    output out_valid, out_sign, out_exponent, out_mag,
    output out_is_zero, out_is_inf, out_is_nan,
    input  out_ready
  );

  modport master (
    output in_valid, in_signs, in_max_exponent,
    output in_mantissas_flat, in_is_infs, in_is_nans,
    input  in_ready,
    input  out_valid, out_sign, out_exponent, out_mag,
    input  out_is_zero, out_is_inf, out_is_nan,
    output out_ready
  );

endinterface

// File: rtl/fp32_signed_pair_add.sv
// Combinational signed adder: sign-extends two W-bit operands.
// Ports: i_a, i_b (W bits, signed) -> o_sum (W+1 bits, signed).
module fp32_signed_pair_add #(
  parameter int W = 28
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_sum
);

  assign o_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};

endmodule

// File: rtl/fp32_mant_sum_pipe.sv
// Sums 8 aligned signed mantissas into sign/magnitude with class flags.
// Ports: clk, rst (sync, active-high), bus (fp32_mant_sum_pipe_if.slave).
// Option FP32_SUM_MID_REG_EN: register between tree levels 2 and 3.
module fp32_mant_sum_pipe
  import fp32_mant_sum_pipe_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  fp32_mant_sum_pipe_if.slave bus
);

  logic              w_adv;
  logic              r_out_valid;
  logic [OP_W-1:0]   w_op [NUM_INPUTS];
  logic [OP_W:0]     w_l1 [4];
  logic [OP_W:0]     r1_l1 [4];
  logic              r1_valid;
  meta_t             r1_meta;
  meta_t             w_meta;
  logic              w_pinf;
  logic              w_ninf;
  logic [SUM_W-1:0]  w_l2 [2];
  logic [SUM_W-1:0]  w_l3_a;
  logic [SUM_W-1:0]  w_l3_b;
  logic [SUM_SW-1:0] w_l3;
  logic              w_s2_valid;
  meta_t             w_s2_meta;

  // Single stall point: every stage advances together.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_op
    assign w_op[i] = to_op(bus.in_signs[i],
      bus.in_mantissas_flat[i*MANT_W +: MANT_W]);
  end

  for (genvar i = 0; i < 4; i++) begin : g_l1
    fp32_signed_pair_add #(.W(OP_W)) u_add (
      .i_a  (w_op[2*i]),
      .i_b  (w_op[2*i+1]),
      .o_sum(w_l1[i])
    );
  end

  assign w_pinf = |(bus.in_is_infs & ~bus.in_signs);
  assign w_ninf = |(bus.in_is_infs & bus.in_signs);

  always_comb begin
    w_meta.exp     = bus.in_max_exponent;
    w_meta.cls     = CLS_NUM;
    w_meta.inf_neg = w_ninf;
    w_meta.all_neg = &bus.in_signs;
    if (|bus.in_is_nans || (w_pinf && w_ninf)) begin
      w_meta.cls = CLS_NAN;
    end else if (w_pinf || w_ninf) begin
      w_meta.cls = CLS_INF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_meta  <= '0;
      for (int i = 0; i < 4; i++) r1_l1[i] <= '0;
    end else if (w_adv) begin
      r1_valid <= bus.in_valid;
      r1_meta  <= w_meta;
      for (int i = 0; i < 4; i++) r1_l1[i] <= w_l1[i];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_l2
    fp32_signed_pair_add #(.W(OP_W+1)) u_add (
      .i_a  (r1_l1[2*i]),
      .i_b  (r1_l1[2*i+1]),
      .o_sum(w_l2[i])
    );
  end

`ifdef FP32_SUM_MID_REG_EN
  logic             r2_valid;
  meta_t            r2_meta;
  logic [SUM_W-1:0] r2_l2a;
  logic [SUM_W-1:0] r2_l2b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_meta  <= '0;
      r2_l2a   <= '0;
      r2_l2b   <= '0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_meta  <= r1_meta;
      r2_l2a   <= w_l2[0];
      r2_l2b   <= w_l2[1];
    end
  end

  assign w_l3_a     = r2_l2a;
  assign w_l3_b     = r2_l2b;
  assign w_s2_valid = r2_valid;
  assign w_s2_meta  = r2_meta;
`else
  assign w_l3_a     = w_l2[0];
  assign w_l3_b     = w_l2[1];
  assign w_s2_valid = r1_valid;
  assign w_s2_meta  = r1_meta;
`endif

  fp32_signed_pair_add #(.W(SUM_W)) u_l3 (
    .i_a  (w_l3_a),
    .i_b  (w_l3_b),
    .o_sum(w_l3)
  );

  logic             w_o_sign;
  logic [EXP_W-1:0] w_o_exp;
  logic [SUM_W-1:0] w_o_mag;
  logic             w_o_zero;
  logic             w_o_inf;
  logic             w_o_nan;

  // |sum| < 2^30 always, so dropping the top bit of abs is lossless.
  always_comb begin
    w_o_sign = w_l3[SUM_SW-1];
    w_o_exp  = w_s2_meta.exp;
    w_o_mag  = w_l3[SUM_SW-1] ? SUM_W'(-w_l3) : w_l3[SUM_W-1:0];
    w_o_zero = 1'b0;
    w_o_inf  = 1'b0;
    w_o_nan  = 1'b0;
    unique case (w_s2_meta.cls)
      CLS_NAN: begin
        w_o_sign = 1'b0;
        w_o_exp  = '1;
        w_o_mag  = '0;
        w_o_nan  = 1'b1;
      end
      CLS_INF: begin
        w_o_sign = w_s2_meta.inf_neg;
        w_o_exp  = '1;
        w_o_mag  = '0;
        w_o_inf  = 1'b1;
      end
      default: begin
        if (w_l3 == '0) begin
          w_o_zero = 1'b1;
          w_o_sign = w_s2_meta.all_neg;
        end
      end
    endcase
  end

  logic             r_sign;
  logic [EXP_W-1:0] r_exp;
  logic [SUM_W-1:0] r_mag;
  logic             r_zero;
  logic             r_inf;
  logic             r_nan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mag       <= '0;
      r_zero      <= 1'b0;
      r_inf       <= 1'b0;
      r_nan       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_s2_valid;
      r_sign      <= w_o_sign;
      r_exp       <= w_o_exp;
      r_mag       <= w_o_mag;
      r_zero      <= w_o_zero;
      r_inf       <= w_o_inf;
      r_nan       <= w_o_nan;
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_sign     = r_sign;
  assign bus.out_exponent = r_exp;
  assign bus.out_mag      = r_mag;
  assign bus.out_is_zero  = r_zero;
  assign bus.out_is_inf   = r_inf;
  assign bus.out_is_nan   = r_nan;

endmodule

// File: tb/tb_fp32_mant_sum_pipe.sv
// Self-checking bench for fp32_mant_sum_pipe: directed cases,
// stall/reset scenarios and a random stream against a sum model.
module tb_fp32_mant_sum_pipe;

`ifdef FP32_SUM_MID_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [7:0]   signs;
    logic [7:0]   exp;
    logic [215:0] mants;
    logic [7:0]   infs;
    logic [7:0]   nans;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [41:0] sb [$];
  bundle_t     pend [$];
  logic [41:0] prev_pack;
  logic [41:0] last_pack;
  logic [41:0] cur_pack;
  bit          prev_stall = 0;
  bit          acc;
  bit          seen_valid;

  always #5 clk = ~clk;

  fp32_mant_sum_pipe_if bus ();

  fp32_mant_sum_pipe u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] pk(input logic s, input logic [7:0] e,
    input logic [29:0] m, input logic z, input logic i, input logic n);
    return {s, e, m, z, i, n};
  endfunction

  // Reference: plain integer sum plus class priority rules.
  function automatic logic [41:0] model(input bundle_t b);
    longint s = 0;
    longint v;
    bit nan = 0, pinf = 0, ninf = 0;
    for (int i = 0; i < 8; i++) begin
      v = 0;
      v[26:0] = b.mants[i*27 +: 27];
      s += b.signs[i] ? -v : v;
      if (b.nans[i]) nan = 1;
      if (b.infs[i]) begin
        if (b.signs[i]) ninf = 1;
        else pinf = 1;
      end
    end
    if (nan || (pinf && ninf)) return pk(0, 8'hFF, 0, 0, 0, 1);
    if (pinf || ninf) return pk(ninf, 8'hFF, 0, 0, 1, 0);
    if (s == 0) return pk(&b.signs, b.exp, 0, 1, 0, 0);
    if (s < 0) return pk(1, b.exp, 30'(-s), 0, 0, 0);
    return pk(0, b.exp, 30'(s), 0, 0, 0);
  endfunction

  function automatic bundle_t uni(input logic [7:0] sg,
    input logic [7:0] e, input logic [26:0] m);
    bundle_t b;
    b.signs = sg;
    b.exp   = e;
    b.infs  = 0;
    b.nans  = 0;
    for (int i = 0; i < 8; i++) b.mants[i*27 +: 27] = m;
    return b;
  endfunction

  function automatic bundle_t rnd_b();
    bundle_t b;
    b.signs = 8'($urandom);
    b.exp   = 8'($urandom);
    for (int i = 0; i < 8; i++)
      b.mants[i*27 +: 27] = ($urandom_range(3) == 0) ?
        27'($urandom_range(7)) : 27'($urandom);
    b.infs = ($urandom_range(7) == 0) ? 8'($urandom & $urandom) : 8'h0;
    b.nans = ($urandom_range(15) == 0) ? 8'($urandom & $urandom) : 8'h0;
    return b;
  endfunction

  task automatic tick(input bit v, input bundle_t b, input bit ordy,
                      input bit do_rst);
    @(negedge clk);
    rst                   = do_rst;
    bus.in_valid          = v;
    bus.in_signs          = b.signs;
    bus.in_max_exponent   = b.exp;
    bus.in_mantissas_flat = b.mants;
    bus.in_is_infs        = b.infs;
    bus.in_is_nans        = b.nans;
    bus.out_ready         = ordy;
    #1;
    acc        = 0;
    seen_valid = bus.out_valid;
    cur_pack   = {bus.out_sign, bus.out_exponent, bus.out_mag,
                  bus.out_is_zero, bus.out_is_inf, bus.out_is_nan};
    if (do_rst) begin
      sb.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 1);
        chk("hold_data", 64'(cur_pack), 64'(prev_pack));
      end
      chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || ordy));
      if (bus.out_valid && ordy) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("out_data", 64'(cur_pack), 64'(sb.pop_front()));
          last_pack = cur_pack;
        end
      end
      if (v && bus.in_ready) begin
        sb.push_back(model(b));
        acc = 1;
      end
      prev_stall = bus.out_valid && !ordy;
      prev_pack  = cur_pack;
    end
  endtask

  task automatic run_one(input string tag, input bundle_t b,
                         input logic [41:0] want);
    int n = 0;
    tick(1, b, 1, 0);
    chk({tag, "_acc"}, 64'(acc), 1);
    do begin
      tick(0, b, 1, 0);
      n++;
    end while (!seen_valid && n < 10);
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    chk({tag, "_val"}, 64'(last_pack), 64'(want));
  endtask

  task automatic run_stream(input int max_cyc, input int st_lo,
    input int st_hi, input int rdy_pct, input int vld_pct);
    int      cyc = 0;
    bit      hold = 0;
    bit      v;
    bit      ordy;
    bundle_t b;
    while ((pend.size() > 0 || sb.size() > 0) && cyc < max_cyc) begin
      ordy = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 :
             ($urandom_range(99) < rdy_pct);
      v = hold || (pend.size() > 0 && $urandom_range(99) < vld_pct);
      b = (pend.size() > 0) ? pend[0] : '0;
      tick(v, b, ordy, 0);
      hold = v && !acc;
      if (acc) void'(pend.pop_front());
      cyc++;
    end
    chk("stream_timeout", 64'(cyc >= max_cyc), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t b;
    bundle_t z = '0;

    tick(0, z, 1, 1);
    tick(0, z, 1, 1);
    tick(0, z, 1, 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_data", 64'(cur_pack), 0);

    run_one("t1_ones", uni(8'h00, 8'd127, 27'h4000000),
            pk(0, 8'd127, 30'h20000000, 0, 0, 0));

    run_one("t2_cancel", uni(8'hF0, 8'd100, 27'h4000000),
            pk(0, 8'd100, 0, 1, 0, 0));
    run_one("t2_negzero", uni(8'hFF, 8'd5, 27'h0),
            pk(1, 8'd5, 0, 1, 0, 0));

    b = uni(8'h02, 8'd90, 27'h0);
    b.mants[26:0]  = 27'h0000003;
    b.mants[53:27] = 27'h4000000;
    run_one("t3_neg", b, pk(1, 8'd90, 30'h3FFFFFD, 0, 0, 0));

    b = uni(8'h02, 8'd40, 27'h1234);
    b.infs = 8'h03;
    run_one("t4_infnan", b, pk(0, 8'hFF, 0, 0, 0, 1));
    b = uni(8'h00, 8'd40, 27'h1234);
    b.infs = 8'h01;
    run_one("t4_pinf", b, pk(0, 8'hFF, 0, 0, 1, 0));
    b = uni(8'h10, 8'd40, 27'h1);
    b.infs = 8'h10;
    run_one("t4_ninf", b, pk(1, 8'hFF, 0, 0, 1, 0));
    b = uni(8'h00, 8'd40, 27'h1);
    b.nans = 8'h80;
    b.infs = 8'h01;
    run_one("t4_nan", b, pk(0, 8'hFF, 0, 0, 0, 1));
    b = uni(8'h00, 8'd255, 27'h7FFFFFF);
    run_one("t_max", b, pk(0, 8'd255, 30'h3FFFFFF8, 0, 0, 0));

    for (int i = 0; i < 5; i++) pend.push_back(rnd_b());
    run_stream(100, 3, 6, 100, 100);
    chk("t5_pend_empty", 64'(pend.size()), 0);
    chk("t5_sb_empty", 64'(sb.size()), 0);

    tick(1, rnd_b(), 1, 0);
    tick(1, rnd_b(), 1, 0);
    tick(0, z, 1, 1);
    tick(0, z, 1, 0);
    chk("t6_flush1", 64'(bus.out_valid), 0);
    tick(0, z, 1, 0);
    chk("t6_flush2", 64'(bus.out_valid), 0);
    run_one("t6_after", uni(8'h00, 8'd127, 27'h4000000),
            pk(0, 8'd127, 30'h20000000, 0, 0, 0));

    for (int i = 0; i < 300; i++) pend.push_back(rnd_b());
    run_stream(5000, -1, -1, 70, 75);
    chk("rand_sb_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
